// File: rtl/reflet_float_mult_arbiter_if.sv
// Two-requester operand/result channels for the shared float multiplier arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
`timescale 1ns/1ps
interface reflet_float_mult_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_in1;
  logic [31:0] req0_in2;
  logic        resp0_valid;
  logic        resp0_ready;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_in1;
  logic [31:0] req1_in2;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [31:0] result;
  logic        busy;

  modport master (
    output req0_valid, req0_in1, req0_in2, resp0_ready,
    output req1_valid, req1_in1, req1_in2, resp1_ready,
    input  req0_ready, resp0_valid, req1_ready, resp1_valid, result, busy
  );

  modport slave (
    input  req0_valid, req0_in1, req0_in2, resp0_ready,
    input  req1_valid, req1_in1, req1_in2, resp1_ready,
    output req0_ready, resp0_valid, req1_ready, resp1_valid, result, busy
  );
endinterface

// File: rtl/reflet_float_mult_arbiter.sv
// Round-robin arbiter sharing one IEEE-754 single multiplier between two requesters.
// The multiplier flushes subnormals to zero and rounds to nearest-even.
`timescale 1ns/1ps
module reflet_float_mult (
  input  logic        enable,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out
);
  logic        sign_s;
  logic [7:0]  ea_s;
  logic [7:0]  eb_s;
  logic [47:0] prod_s;
  logic [22:0] mant_s;
  logic        guard_s;
  logic        sticky_s;
  logic        rnd_s;
  logic [23:0] rounded_s;
  logic [9:0]  exp_s;
  logic [9:0]  exp_f_s;
  logic        nan_s;
  logic        inf1_s;
  logic        inf2_s;
  logic        zero1_s;
  logic        zero2_s;
  logic [31:0] res_s;

  // Normalise the 48-bit significand product and round to nearest-even.
  always_comb begin
    sign_s  = in1[31] ^ in2[31];
    ea_s    = in1[30:23];
    eb_s    = in2[30:23];
    prod_s  = {24'h000000, 1'b1, in1[22:0]} * {24'h000000, 1'b1, in2[22:0]};
    if (prod_s[47]) begin
      mant_s   = prod_s[46:24];
      guard_s  = prod_s[23];
      sticky_s = |prod_s[22:0];
      exp_s    = {2'b00, ea_s} + {2'b00, eb_s} - 10'd126;
    end else begin
      mant_s   = prod_s[45:23];
      guard_s  = prod_s[22];
      sticky_s = |prod_s[21:0];
      exp_s    = {2'b00, ea_s} + {2'b00, eb_s} - 10'd127;
    end
    rnd_s     = guard_s & (sticky_s | mant_s[0]);
    rounded_s = {1'b0, mant_s} + {23'd0, rnd_s};
    exp_f_s   = exp_s + {9'd0, rounded_s[23]};

    nan_s   = ((ea_s == 8'hFF) && (in1[22:0] != 23'd0)) || ((eb_s == 8'hFF) && (in2[22:0] != 23'd0));
    inf1_s  = (ea_s == 8'hFF) && (in1[22:0] == 23'd0);
    inf2_s  = (eb_s == 8'hFF) && (in2[22:0] == 23'd0);
    zero1_s = (ea_s == 8'h00);
    zero2_s = (eb_s == 8'h00);

    // Infinity times zero is invalid and yields the canonical quiet NaN.
    if (nan_s) begin
      res_s = 32'h7FC00000;
    end else if (inf1_s || inf2_s) begin
      if (zero1_s || zero2_s) res_s = 32'h7FC00000;
      else                    res_s = {sign_s, 8'hFF, 23'd0};
    end else if (zero1_s || zero2_s) begin
      res_s = {sign_s, 31'd0};
    end else if (exp_f_s[9] || (exp_f_s == 10'd0)) begin
      res_s = {sign_s, 31'd0};
    end else if (exp_f_s >= 10'd255) begin
      res_s = {sign_s, 8'hFF, 23'd0};
    end else begin
      res_s = {sign_s, exp_f_s[7:0], rounded_s[22:0]};
    end

    if (enable) out = res_s;
    else        out = 32'h00000000;
  end
endmodule

module reflet_float_mult_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                        clk,
  input logic                        reset,
  reflet_float_mult_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] result_q, result_d;
  logic        grant_s;
  logic        idle_s;
  logic        accept_s;
  logic        resp_done_s;
  logic [31:0] mult_out_s;

  reflet_float_mult u_mult (
    .enable (1'b1),
    .in1    (op1_q),
    .in2    (op2_q),
    .out    (mult_out_s)
  );

  // Pointer only breaks ties; a lone requester is always granted.
  always_comb begin
    grant_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_s = ptr_q;
    else if (bus.req1_valid)              grant_s = 1'b1;
    else                                  grant_s = 1'b0;
  end

  assign idle_s          = (state_q == S_IDLE);
  assign bus.req0_ready  = idle_s && !grant_s && bus.req0_valid;
  assign bus.req1_ready  = idle_s &&  grant_s && bus.req1_valid;
  assign accept_s        = bus.req0_ready || bus.req1_ready;
  assign resp_done_s     = (state_q == S_RESP) && (owner_q ? bus.resp1_ready : bus.resp0_ready);
  assign bus.resp0_valid = (state_q == S_RESP) && !owner_q;
  assign bus.resp1_valid = (state_q == S_RESP) &&  owner_q;
  assign bus.result      = result_q;
  assign bus.busy        = !idle_s;

  // Next-state and datapath updates for IDLE -> EXEC -> RESP.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op1_d   = grant_s ? bus.req1_in1 : bus.req0_in1;
          op2_d   = grant_s ? bus.req1_in2 : bus.req0_in2;
          owner_d = grant_s;
          cnt_d   = CNT_INIT;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          result_d = mult_out_s;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_done_s) begin
          state_d = S_IDLE;
          ptr_d   = ~owner_q;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= 4'd0;
      op1_q    <= 32'h00000000;
      op2_q    <= 32'h00000000;
      result_q <= 32'h00000000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
    end
  end
endmodule
